// File: rtl/sequencer.sv
// Control FSM for the basic processor. It runs fetch/decode/execute over PC, MAR, IR and memory, and drives the ALU.
// Moore outputs are decoded from the state, the IR opcode, and z_flag (branch only). run is sampled only at instruction boundaries.
module sequencer #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic            run,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  output logic            Addr_PC,
  output logic            load_MAR,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            CS,
  output logic            R_NW,
  output logic            load_IR,
  output logic            ACC_bus,
  output logic            load_REG,
  output logic            ALU_REG,
  output logic            ALU_add,
  output logic            ALU_sub,
  output logic            halted
);

  if (OP_W > WORD_W) begin : g_bad_width
    $error("opcode field wider than the instruction word");
  end

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_ADDR,
    S_FETCH_DATA,
    S_DECODE,
    S_EXEC_READ,
    S_EXEC_WRITE,
    S_BRANCH,
    S_HALT
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // At an instruction boundary, run decides between the next fetch and parking in IDLE.
  state_t boundary;
  always_comb begin
    boundary = run ? S_FETCH_ADDR : S_IDLE;
  end

  always_comb begin
    state_d  = state_q;
    Addr_PC  = 1'b0;
    load_MAR = 1'b0;
    load_PC  = 1'b0;
    INC_PC   = 1'b0;
    CS       = 1'b0;
    R_NW     = 1'b0;
    load_IR  = 1'b0;
    ACC_bus  = 1'b0;
    load_REG = 1'b0;
    ALU_REG  = 1'b0;
    ALU_add  = 1'b0;
    ALU_sub  = 1'b0;
    halted   = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = boundary;
      end
      S_FETCH_ADDR: begin
        Addr_PC  = 1'b1;
        load_MAR = 1'b1;
        load_PC  = 1'b1;
        INC_PC   = 1'b1;
        state_d  = S_FETCH_DATA;
      end
      S_FETCH_DATA: begin
        CS      = 1'b1;
        R_NW    = 1'b1;
        load_IR = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // The operand address goes to MAR. Opcodes not listed here are NOPs.
        load_MAR = 1'b1;
        case (op)
          OP_LOAD, OP_ADD, OP_SUB: state_d = S_EXEC_READ;
          OP_STORE:                state_d = S_EXEC_WRITE;
          OP_BNE:                  state_d = S_BRANCH;
          OP_HALT:                 state_d = S_HALT;
          default:                 state_d = boundary;
        endcase
      end
      S_EXEC_READ: begin
        CS       = 1'b1;
        R_NW     = 1'b1;
        load_REG = 1'b1;
        ALU_REG  = (op == OP_ADD) || (op == OP_SUB);
        ALU_add  = (op == OP_ADD);
        ALU_sub  = (op == OP_SUB);
        state_d  = boundary;
      end
      S_EXEC_WRITE: begin
        CS      = 1'b1;
        ACC_bus = 1'b1;
        state_d = boundary;
      end
      S_BRANCH: begin
        // A taken branch loads the PC from the IR operand, not PC+1.
        load_PC = ~z_flag;
        state_d = boundary;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/sequencer.md
Name: sequencer

Overview:
- Control unit for the basic processor. It drives the accumulator/ALU control inputs (load_REG, ALU_REG, ALU_add, ALU_sub) and samples that block's z_flag.
- Sequences fetch/decode/execute over the shared address path, memory, PC, MAR and IR.
- Moore FSM; every control output is decoded combinationally from the state register, the registered opcode, and z_flag (BRANCH state only).

Parameters:
WORD_W, 8, datapath word width (PC/MAR/IR sizing in the datapath; carried here for consistency)
OP_W, 3, opcode width; opcode = IR[WORD_W-1 -: OP_W], presented on op

Ports:
clock  input  1  system clock, rising edge
n_reset  input  1  asynchronous active-low reset
run  input  1  1 = fetch and execute instructions; 0 = park in IDLE at the next instruction boundary
op  input  OP_W  opcode field from IR
z_flag  input  1  accumulator-zero flag from ALU
Addr_PC  output  1  address mux: 1 = PC, 0 = IR operand
load_MAR  output  1  MAR load enable
load_PC  output  1  PC load enable
INC_PC  output  1  with load_PC: 1 = PC+1, 0 = PC from IR operand
CS  output  1  memory chip select
R_NW  output  1  1 = read, 0 = write; meaningful only with CS
load_IR  output  1  IR load from memory data
ACC_bus  output  1  drive accumulator onto memory write data
load_REG  output  1  ALU accumulator load enable
ALU_REG  output  1  1 = accumulator op, 0 = load memory data
ALU_add  output  1  select add
ALU_sub  output  1  select subtract
halted  output  1  FSM is in HALT

Behaviour:
- Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 BNE, 111 HALT. 101 and 110 execute as NOP.
- States: IDLE, FETCH_ADDR, FETCH_DATA, DECODE, EXEC_READ, EXEC_WRITE, BRANCH, HALT. Unlisted outputs are 0.
- Reset (asynchronous): state = IDLE. All outputs 0 while n_reset is low and in IDLE, including halted = 0. Reset mid-instruction aborts it immediately; no partial strobes after deassertion.
- IDLE: no outputs. run = 1 -> FETCH_ADDR, else stay.
- FETCH_ADDR: Addr_PC = 1, load_MAR = 1, load_PC = 1, INC_PC = 1. -> FETCH_DATA.
- FETCH_DATA: CS = 1, R_NW = 1, load_IR = 1. -> DECODE.
- DECODE: Addr_PC = 0, load_MAR = 1. Next state by op:
  - LOAD, ADD, SUB -> EXEC_READ
  - STORE -> EXEC_WRITE
  - BNE -> BRANCH
  - HALT -> HALT
  - NOP -> boundary
- EXEC_READ: CS = 1, R_NW = 1, load_REG = 1. ALU_REG = 1 for ADD or SUB; ALU_add = 1 only for ADD; ALU_sub = 1 only for SUB; never both. -> boundary.
- EXEC_WRITE: CS = 1, R_NW = 0, ACC_bus = 1. -> boundary.
- BRANCH: if z_flag = 0, load_PC = 1 and INC_PC = 0 (PC <= operand). If z_flag = 1, no PC load. -> boundary.
- HALT: halted = 1, nothing else. Leaves only via reset; run is ignored.
- Boundary: run = 1 -> FETCH_ADDR, run = 0 -> IDLE. run is sampled only at IDLE and at boundaries; dropping run mid-instruction completes the instruction.
- Timing:
  - LOAD/ADD/SUB/STORE/BNE: 4 cycles each.
  - NOP: 3 cycles.
  - Back-to-back with run held high: no idle cycles.
- z_flag is sampled in BRANCH. It reflects the accumulator written at the previous instruction's EXEC_READ edge.
- Invariants:
  - load_IR only in FETCH_DATA.
  - CS never asserted in DECODE.
  - R_NW = 0 only together with ACC_bus = 1.

Test Plan:
- Reset then run = 0 for 10 cycles -> all outputs 0, state IDLE. Raise run -> next cycle Addr_PC = load_MAR = load_PC = INC_PC = 1.
- run = 1, op = 010 (ADD) -> FETCH_ADDR, FETCH_DATA, DECODE, EXEC_READ. EXEC_READ shows CS = R_NW = load_REG = ALU_REG = ALU_add = 1, ALU_sub = 0. Next cycle is FETCH_ADDR. Repeat with 011 -> ALU_sub = 1, ALU_add = 0; with 000 -> ALU_REG = 0.
- op = 001 (STORE) -> 4th cycle CS = 1, R_NW = 0, ACC_bus = 1, load_REG = 0.
- op = 100 with z_flag = 0 -> 4th cycle load_PC = 1, INC_PC = 0. Same with z_flag = 1 -> load_PC = 0. Both return to FETCH_ADDR.
- op = 111 -> halted = 1 from cycle 4 and held for 20 cycles with run toggling. Pulse n_reset low -> halted = 0, IDLE.
- Drop run during FETCH_DATA of an ADD -> ADD completes (load_REG pulse), then IDLE. n_reset low during EXEC_READ -> load_REG drops immediately; after release, IDLE with all outputs 0.
